// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-operand and HI/LO hazards,
// plus the mult/div busy sequencer. Define HAZ_PERF_CNT_EN to add the stall_cycles counter.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   input  logic [31:0] instr_e,
   input  logic [31:0] instr_m,
   output logic        stall_pc,
   output logic        stall_fd,
   output logic        flush_de,
   output logic        md_start,
   output logic        md_busy,
   output logic [3:0]  md_count
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
   localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;

   logic [5:0] op_d, fn_d, op_e, fn_e, op_m;
   logic [4:0] rs_d, rt_d, rt_e, rd_e, rt_m;

   logic       e_is_load, e_md_issue, e_r_write, e_i_write;
   logic [4:0] dest_e, m_load_rt;
   logic       d_branch, d_jr, d_md_use;
   logic       br_rs, br_rt;
   logic       lu_haz, br_haz, md_haz, stall;

   assign op_d = instr_d[31:26];
   assign fn_d = instr_d[5:0];
   assign rs_d = instr_d[25:21];
   assign rt_d = instr_d[20:16];
   assign op_e = instr_e[31:26];
   assign fn_e = instr_e[5:0];
   assign rt_e = instr_e[20:16];
   assign rd_e = instr_e[15:11];
   assign op_m = instr_m[31:26];
   assign rt_m = instr_m[20:16];

   always_comb begin
      e_is_load  = (op_e == 6'h23);
      e_md_issue = (op_e == 6'h00) && (fn_e[5:2] == 4'b0110);
      // jr and mult/div write no GPR even though they are R-type
      e_r_write  = (op_e == 6'h00) && (fn_e != 6'h08) && !e_md_issue;
      e_i_write  = e_is_load || (op_e[5:3] == 3'b001);
      dest_e     = e_r_write ? rd_e : (e_i_write ? rt_e : 5'd0);
      m_load_rt  = (op_m == 6'h23) ? rt_m : 5'd0;

      d_branch   = (op_d == 6'h04) || (op_d == 6'h05);
      d_jr       = (op_d == 6'h00) && (fn_d == 6'h08);
      d_md_use   = (op_d == 6'h00) && ((fn_d[5:2] == 4'b0100) || (fn_d[5:2] == 4'b0110));

      lu_haz     = e_is_load && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));
      br_rs      = ((dest_e != 5'd0) && (dest_e == rs_d)) ||
                   ((m_load_rt != 5'd0) && (m_load_rt == rs_d));
      br_rt      = ((dest_e != 5'd0) && (dest_e == rt_d)) ||
                   ((m_load_rt != 5'd0) && (m_load_rt == rt_d));
      br_haz     = (d_branch && (br_rs || br_rt)) || (d_jr && br_rs);
      md_haz     = d_md_use && (e_md_issue || (state_q == StBusy));
      stall      = lu_haz || br_haz || md_haz;
   end

   assign stall_pc = stall;
   assign stall_fd = stall;
   assign flush_de = stall;
   assign md_start = e_md_issue;
   assign md_busy  = (state_q == StBusy);
   assign md_count = count_q;

   // A second issue while busy cannot happen in a correctly stalled pipeline; it is ignored.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (e_md_issue) begin
               state_d = StBusy;
               count_d = fn_e[1] ? DivLoad : MultLoad;
            end
         end
         StBusy: begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            count_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed hazard scenarios followed by random
// instruction triples, checked against a cycle-count reference model.
module tb_hazard_stall_ctrl;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_d, instr_e, instr_m;
   logic        stall_pc, stall_fd, flush_de, md_start, md_busy;
   logic [3:0]  md_count;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   hazard_stall_ctrl #(
      .MULT_CYCLES(MultN),
      .DIV_CYCLES (DivN)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .instr_d (instr_d),
      .instr_e (instr_e),
      .instr_m (instr_m),
      .stall_pc(stall_pc),
      .stall_fd(stall_fd),
      .flush_de(flush_de),
      .md_start(md_start),
      .md_busy (md_busy),
      .md_count(md_count)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        start;
      logic        busy;
      logic [3:0]  count;
      logic [31:0] cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference state: cycles of mult/div work still outstanding, and total stall cycles.
   int          busy_left;
   logic [31:0] stall_total;

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] i_ins(int op, int rs, int rt);
      return {6'(op), 5'(rs), 5'(rt), 16'h0004};
   endfunction

   function automatic int f_op(logic [31:0] i);  return int'(i[31:26]); endfunction
   function automatic int f_fn(logic [31:0] i);  return int'(i[5:0]);   endfunction
   function automatic int f_rs(logic [31:0] i);  return int'(i[25:21]); endfunction
   function automatic int f_rt(logic [31:0] i);  return int'(i[20:16]); endfunction
   function automatic int f_rd(logic [31:0] i);  return int'(i[15:11]); endfunction

   function automatic bit is_md_issue(logic [31:0] i);
      return f_op(i) == 0 && f_fn(i) >= 'h18 && f_fn(i) <= 'h1B;
   endfunction

   function automatic bit is_md_use(logic [31:0] i);
      return is_md_issue(i) || (f_op(i) == 0 && f_fn(i) >= 'h10 && f_fn(i) <= 'h13);
   endfunction

   // GPR written by an instruction, 0 if none.
   function automatic int dest_of(logic [31:0] i);
      if (f_op(i) == 0) begin
         if (f_fn(i) == 'h08 || is_md_issue(i)) return 0;
         return f_rd(i);
      end
      if (f_op(i) == 'h23 || (f_op(i) >= 'h08 && f_op(i) <= 'h0F)) return f_rt(i);
      return 0;
   endfunction

   function automatic bit model_stall(logic [31:0] d, logic [31:0] e, logic [31:0] m, int busy);
      int  reads[$];
      bit  hz;
      hz = 1'b0;
      if (f_op(e) == 'h23 && f_rt(e) != 0 && (f_rt(e) == f_rs(d) || f_rt(e) == f_rt(d)))
         hz = 1'b1;
      if (f_op(d) == 'h04 || f_op(d) == 'h05) reads = '{f_rs(d), f_rt(d)};
      else if (f_op(d) == 0 && f_fn(d) == 'h08) reads = '{f_rs(d)};
      foreach (reads[k]) begin
         if (dest_of(e) != 0 && dest_of(e) == reads[k]) hz = 1'b1;
         if (f_op(m) == 'h23 && f_rt(m) != 0 && f_rt(m) == reads[k]) hz = 1'b1;
      end
      if (is_md_use(d) && (is_md_issue(e) || busy > 0)) hz = 1'b1;
      return hz;
   endfunction

   function automatic logic [31:0] rand_instr();
      int a, b, c;
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      case ($urandom_range(0, 14))
         0:  return 32'd0;
         1:  return i_ins('h23, a, b);
         2:  return i_ins('h2B, a, b);
         3:  return r_ins(a, b, c, 'h20);
         4:  return i_ins('h08, a, b);
         5:  return i_ins('h04, a, b);
         6:  return i_ins('h05, a, b);
         7:  return r_ins(a, 0, 0, 'h08);
         8:  return r_ins(a, b, 0, 'h18 + $urandom_range(0, 3));
         9:  return r_ins(0, 0, c, 'h10);
         10: return r_ins(0, 0, c, 'h12);
         11: return r_ins(a, 0, 0, 'h11);
         12: return r_ins(a, b, c, 'h25);
         13: return i_ins('h0D, a, b);
         default: return 32'd0;
      endcase
   endfunction

   // One clock cycle: drive, push expectation, advance the reference across the next edge.
   task automatic step(input logic rst, input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m);
      exp_t x;
      @(posedge clk);
      #1;
      reset   = rst;
      instr_d = d;
      instr_e = e;
      instr_m = m;
      x.stall = model_stall(d, e, m, busy_left);
      x.start = is_md_issue(e);
      x.busy  = busy_left > 0;
      x.count = 4'(busy_left);
      x.cyc   = stall_total;
      sb.push_back(x);
      if (rst) begin
         busy_left   = 0;
         stall_total = 32'd0;
      end else begin
         if (busy_left > 0) busy_left--;
         else if (is_md_issue(e)) busy_left = (f_fn(e) >= 'h1A) ? int'(DivN) : int'(MultN);
         if (x.stall) stall_total = stall_total + 32'd1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("stall_pc", 32'(stall_pc), 32'(x.stall));
         chk("stall_fd", 32'(stall_fd), 32'(x.stall));
         chk("flush_de", 32'(flush_de), 32'(x.stall));
         chk("md_start", 32'(md_start), 32'(x.start));
         chk("md_busy", 32'(md_busy), 32'(x.busy));
         chk("md_count", 32'(md_count), 32'(x.count));
`ifdef HAZ_PERF_CNT_EN
         chk("stall_cycles", stall_cycles, x.cyc);
`endif
      end
   end

   initial begin
      logic [31:0] mflo3, add_dep, beq5, add5, lw5;
      reset   = 1'b1;
      instr_d = 32'd0;
      instr_e = 32'd0;
      instr_m = 32'd0;
      repeat (2) @(posedge clk);
      busy_left   = 0;
      stall_total = 32'd0;

      step(1'b1, 32'd0, 32'd0, 32'd0);
      step(1'b0, 32'd0, 32'd0, 32'd0);

      // load-use: lw $2 in E, add $3,$2,$4 in D
      add_dep = r_ins(2, 4, 3, 'h20);
      step(1'b0, add_dep, i_ins('h23, 1, 2), 32'd0);
      step(1'b0, add_dep, 32'd0, i_ins('h23, 1, 2));

      // branch after ALU, then after load in M
      beq5 = i_ins('h04, 5, 0);
      add5 = r_ins(1, 1, 5, 'h20);
      lw5  = i_ins('h23, 1, 5);
      step(1'b0, beq5, add5, 32'd0);
      step(1'b0, beq5, 32'd0, lw5);
      step(1'b0, beq5, 32'd0, 32'd0);
      step(1'b0, beq5, lw5, 32'd0);
      step(1'b0, beq5, 32'd0, lw5);
      step(1'b0, beq5, 32'd0, 32'd0);

      // mult then dependent mflo
      mflo3 = r_ins(0, 0, 3, 'h12);
      step(1'b1, 32'd0, 32'd0, 32'd0);
      step(1'b0, mflo3, r_ins(1, 2, 0, 'h18), 32'd0);
      repeat (7) step(1'b0, mflo3, 32'd0, 32'd0);

      // div with an independent instruction in D
      step(1'b0, add_dep, r_ins(1, 2, 0, 'h1A), 32'd0);
      repeat (11) step(1'b0, add_dep, 32'd0, 32'd0);

      // reset while busy with md_count = 3
      step(1'b0, 32'd0, r_ins(1, 2, 0, 'h19), 32'd0);
      step(1'b0, mflo3, 32'd0, 32'd0);
      step(1'b0, mflo3, 32'd0, 32'd0);
      step(1'b1, mflo3, 32'd0, 32'd0);
      step(1'b0, mflo3, 32'd0, 32'd0);
      step(1'b0, mflo3, 32'd0, 32'd0);

      // load into $0 never stalls
      step(1'b0, r_ins(0, 0, 3, 'h20), i_ins('h23, 1, 0), 32'd0);
      step(1'b0, i_ins('h04, 0, 0), r_ins(1, 1, 0, 'h20), i_ins('h23, 1, 0));

      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) == 0), rand_instr(), rand_instr(), rand_instr());
      end
      step(1'b0, 32'd0, 32'd0, 32'd0);

      for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      end
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
